// File: rtl/uart_receive.sv
// 8N1 UART receiver: oversamples rx with clk, frames LSB-first bytes into a valid/ready holding register.
// Optional `UART_RX_GLITCH_FILTER_EN adds a registered 2-of-3 majority filter on the synchronised line.
module uart_receive #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [31:0]            cnt;
    logic [31:0]            div_eff;
    logic [31:0]            half;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    assign div_eff = (clk_div < 32'd4) ? 32'd4 : clk_div;
    assign half    = div_eff >> 1;

    // sync[0] is the first stage, sync[SYNC_STAGES-1] the line as seen by the FSM
    always_ff @(posedge clk) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rx};
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic sync_q;
    logic rx_filt;
    logic maj;

    // Vote over three consecutive synchroniser outputs: the one being loaded now,
    // the current one, and the previous one, so a clean edge costs exactly one cycle.
    assign maj = (sync[SYNC_STAGES-2] & sync[SYNC_STAGES-1]) |
                 (sync[SYNC_STAGES-2] & sync_q) |
                 (sync[SYNC_STAGES-1] & sync_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            rx_filt <= 1'b1;
        end else begin
            sync_q  <= sync[SYNC_STAGES-1];
            rx_filt <= maj;
        end
    end

    assign rxs = rx_filt;
`else
    assign rxs = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == half - 32'd1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == div_eff - 32'd1) begin
                        shreg[bit_idx] <= rxs;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    // Returning to IDLE mid stop bit leaves half a bit to catch a back-to-back start
                    if (cnt == div_eff - 32'd1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rxs) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid && !rx_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receive.sv
// Randomised self-checking bench for uart_receive: serial frames driven from a byte-level model,
// received bytes and error pulses compared against expected queues and counts.
module tb_uart_receive;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] clk_div;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    always #5 clk = ~clk;

    uart_receive #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    int         n_chk  = 0;
    int         n_err  = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       busy_mid = 1'b0;
    logic       busy_end = 1'b0;

    // A byte is newly presented when valid is high and the previous one was absent, accepted or overrun
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid && (!pv || pr || overrun)) got_q.push_back(rx_data);
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
        end
        pv = rx_valid;
        pr = rx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the first nbits bits of an 8N1 frame (start, 8 data LSB first, stop), div clocks each
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            step(div);
            if (i == 5) busy_mid = busy;
        end
        busy_end = busy;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int f0;
        int o0;
        int d;
        int ferr_exp;
        logic [7:0] b;
        logic bad;

        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1; clk_div = 32'd16;
        step(3);
        chk("rst_data",  32'(rx_data),   32'h00);
        chk("rst_valid", 32'(rx_valid),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        step(5);

        // clean frame
        send_frame(8'hA5, 16, 1'b1, 10);
        exp_q.push_back(8'hA5);
        step(20);
        check_rx("a5");
        chk("a5_ferr",     32'(n_ferr),   32'd0);
        chk("a5_ovr",      32'(n_ovr),    32'd0);
        chk("a5_busy_mid", 32'(busy_mid), 32'd1);
        chk("a5_busy_end", 32'(busy_end), 32'd0);

        // bad stop bit, then a good frame
        f0 = n_ferr;
        send_frame(8'h3C, 16, 1'b0, 10);
        rx = 1'b1;
        step(40);
        chk("ferr_pulse", 32'(n_ferr - f0), 32'd1);
        chk("ferr_valid", 32'(rx_valid),    32'd0);
        chk("ferr_count", 32'(got_q.size()), 32'd0);
        send_frame(8'h55, 16, 1'b1, 10);
        exp_q.push_back(8'h55);
        step(20);
        check_rx("after_ferr");

        // false start: rx low for 3 cycles
        f0 = n_ferr;
        rx = 1'b0;
        step(2);
        chk("fs_busy_early", 32'(busy), 32'd0);
        step(1);
        rx = 1'b1;
        step(1);
        chk("fs_busy_high", 32'(busy), 32'd1);
        step(30);
        chk("fs_busy_low", 32'(busy),           32'd0);
        chk("fs_ferr",     32'(n_ferr - f0),    32'd0);
        chk("fs_bytes",    32'(got_q.size()),   32'd0);

        // back-to-back with consumer stalled
        rx_ready = 1'b0; clk_div = 32'd10;
        o0 = n_ovr;
        send_frame(8'h01, 10, 1'b1, 10);
        send_frame(8'hFF, 10, 1'b1, 10);
        step(5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        check_rx("b2b");
        chk("b2b_ovr",   32'(n_ovr - o0), 32'd1);
        chk("b2b_valid", 32'(rx_valid),   32'd1);
        chk("b2b_data",  32'(rx_data),    32'hFF);

        // reset during data bit 4, with a byte still held
        clk_div = 32'd16;
        o0 = n_ovr;
        send_frame(8'h96, 16, 1'b1, 5);
        rx = 1'b1;
        step(8);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_data",  32'(rx_data),   32'h00);
        chk("mid_rst_valid", 32'(rx_valid),  32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ferr",  32'(frame_err), 32'd0);
        chk("mid_rst_ovr",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        step(40);
        send_frame(8'h5A, 16, 1'b1, 10);
        exp_q.push_back(8'h5A);
        step(5);
        check_rx("post_rst");
        chk("post_rst_valid", 32'(rx_valid),    32'd1);
        chk("post_rst_data",  32'(rx_data),     32'h5A);
        chk("post_rst_ovr",   32'(n_ovr - o0),  32'd0);
        rx_ready = 1'b1;
        step(2);
        chk("drain_valid", 32'(rx_valid), 32'd0);

        // divisor clamp: 0 and 4 both mean 4 clocks per bit
        clk_div = 32'd0;
        send_frame(8'hC3, 4, 1'b1, 10);
        exp_q.push_back(8'hC3);
        step(10);
        clk_div = 32'd4;
        send_frame(8'hC3, 4, 1'b1, 10);
        exp_q.push_back(8'hC3);
        step(10);
        check_rx("div_clamp");

        // transmitter-style loopback at 8 clocks per bit
        clk_div = 32'd8;
        send_frame(8'h00, 8, 1'b1, 10); exp_q.push_back(8'h00); step(8);
        send_frame(8'h80, 8, 1'b1, 10); exp_q.push_back(8'h80); step(8);
        send_frame(8'h7E, 8, 1'b1, 10); exp_q.push_back(8'h7E); step(8);
        check_rx("loop");

        // randomised frames, divisors and stop-bit errors
        f0 = n_ferr; o0 = n_ovr; ferr_exp = 0;
        for (int k = 0; k < 24; k++) begin
            d = int'($urandom_range(4, 20));
            clk_div = (d == 4 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'(d);
            b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, d, !bad, 10);
            rx = 1'b1;
            if (bad) ferr_exp++;
            else begin
                exp_q.push_back(b);
                if (d >= 8) chk("rnd_busy_end", 32'(busy_end), 32'd0);
            end
            step(2 * d + int'($urandom_range(0, d)));
        end
        check_rx("rnd");
        chk("rnd_ferr", 32'(n_ferr - f0), 32'(ferr_exp));
        chk("rnd_ovr",  32'(n_ovr - o0),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
